// File: rtl/sensor_emulator.sv
// sensor_emulator
//
// Single-wire DHT11 responder. It watches the shared open-drain line for a
// host start pulse (line held low for at least START_MIN_US). Once the host
// releases the line it answers with the standard DHT11 frame:
//   response low / response high,
//   40 bits: hum_int, hum_float, temp_int, temp_float, checksum, each MSB first.
// Each bit is a BIT_LOW_US low preamble followed by a high time of
// ZERO_HIGH_US (0) or ONE_HIGH_US (1). The frame ends with a BIT_LOW_US low
// end marker, then the line is released.
//
// Ports
//   clock             : single clock, rising edge
//   reset             : asynchronous, active-high
//   enable            : 1 = accept new start requests (a running frame always completes)
//   transmission_line : open-drain line, driven only to 0 or z (external pull-up)
//   hum_int/hum_float/temp_int/temp_float : payload bytes, latched at host release
//   bad_checksum      : 1 = flip checksum bit 0 (deliberately wrong checksum)
//   busy              : high from start-request acceptance to end of frame
//   done              : one-cycle pulse on the first released cycle after the frame

module sensor_emulator #(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_WAIT_US  = 30,
    parameter int unsigned RESP_LOW_US   = 80,
    parameter int unsigned RESP_HIGH_US  = 80,
    parameter int unsigned BIT_LOW_US    = 50,
    parameter int unsigned ZERO_HIGH_US  = 26,
    parameter int unsigned ONE_HIGH_US   = 70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    inout  wire        transmission_line,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic       bad_checksum,
    output logic       busy,
    output logic       done
);

    localparam logic [31:0] START_LEN     = 32'(START_MIN_US * CYCLES_PER_US);
    localparam logic [31:0] RESP_WAIT_LEN = 32'(RESP_WAIT_US * CYCLES_PER_US);
    localparam logic [31:0] RESP_LOW_LEN  = 32'(RESP_LOW_US * CYCLES_PER_US);
    localparam logic [31:0] RESP_HIGH_LEN = 32'(RESP_HIGH_US * CYCLES_PER_US);
    localparam logic [31:0] BIT_LOW_LEN   = 32'(BIT_LOW_US * CYCLES_PER_US);
    localparam logic [31:0] ZERO_LEN      = 32'(ZERO_HIGH_US * CYCLES_PER_US);
    localparam logic [31:0] ONE_LEN       = 32'(ONE_HIGH_US * CYCLES_PER_US);

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RELEASE,
        RESP_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t      state, state_n;
    logic        sync1, line_s, line_prev;
    logic [31:0] timer;
    logic [31:0] phase_len;
    logic        phase_end;
    logic [39:0] shreg;
    logic [5:0]  bit_cnt;
    logic        drive_low;
    logic        do_latch, do_shift;
    logic [7:0]  checksum;

    // Open-drain output: only ever pull low or release.
    assign transmission_line = drive_low ? 1'b0 : 1'bz;

    // 8-bit result of the sum is the 10-bit sum truncated to 8 bits.
    assign checksum = (hum_int + hum_float + temp_int + temp_float) ^ {7'd0, bad_checksum};

    // Length of the current phase in cycles; BIT_HIGH length depends on the
    // bit at the head of the shift register.
    always_comb begin
        phase_len = 32'd1;
        case (state)
            START_LOW: phase_len = START_LEN;
            RESP_WAIT: phase_len = RESP_WAIT_LEN;
            RESP_LOW:  phase_len = RESP_LOW_LEN;
            RESP_HIGH: phase_len = RESP_HIGH_LEN;
            BIT_LOW:   phase_len = BIT_LOW_LEN;
            BIT_HIGH:  phase_len = shreg[39] ? ONE_LEN : ZERO_LEN;
            END_LOW:   phase_len = BIT_LOW_LEN;
            default:   phase_len = 32'd1;
        endcase
    end

    assign phase_end = (timer == phase_len - 32'd1);

    always_comb begin
        state_n  = state;
        do_latch = 1'b0;
        do_shift = 1'b0;
        case (state)
            IDLE: begin
                // Fresh falling edge only: avoids retriggering off our own END_LOW,
                // which is still visible on line_s for two cycles after release.
                if (enable && line_prev && !line_s)
                    state_n = START_LOW;
            end
            START_LOW: begin
                if (line_s)
                    state_n = IDLE;
                else if (phase_end)
                    state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (line_s) begin
                    state_n  = RESP_WAIT;
                    do_latch = 1'b1;
                end
            end
            RESP_WAIT: if (phase_end) state_n = RESP_LOW;
            RESP_LOW:  if (phase_end) state_n = RESP_HIGH;
            RESP_HIGH: if (phase_end) state_n = BIT_LOW;
            BIT_LOW:   if (phase_end) state_n = BIT_HIGH;
            BIT_HIGH: begin
                if (phase_end) begin
                    if (bit_cnt == 6'd39) begin
                        state_n = END_LOW;
                    end else begin
                        state_n  = BIT_LOW;
                        do_shift = 1'b1;
                    end
                end
            end
            END_LOW:   if (phase_end) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            line_s    <= 1'b1;
            line_prev <= 1'b1;
            state     <= IDLE;
            timer     <= 32'd0;
            shreg     <= 40'd0;
            bit_cnt   <= 6'd0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sync1     <= transmission_line;
            line_s    <= sync1;
            line_prev <= line_s;
            state     <= state_n;

            // Timer restarts on every phase change and stays parked where
            // no phase is being timed (WAIT_RELEASE may last indefinitely).
            if (state_n != state || state == IDLE || state == WAIT_RELEASE)
                timer <= 32'd0;
            else
                timer <= timer + 32'd1;

            if (do_latch) begin
                shreg   <= {hum_int, hum_float, temp_int, temp_float, checksum};
                bit_cnt <= 6'd0;
            end else if (do_shift) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_cnt <= bit_cnt + 6'd1;
            end

            // Registered from the next state so the line level lines up
            // exactly with the driving states.
            drive_low <= (state_n == RESP_LOW) || (state_n == BIT_LOW) ||
                         (state_n == END_LOW);

            if (state == START_LOW && state_n == WAIT_RELEASE)
                busy <= 1'b1;
            else if (state == END_LOW && state_n == IDLE)
                busy <= 1'b0;

            done <= (state == END_LOW) && (state_n == IDLE);
        end
    end

endmodule
